// File: rtl/my_nios1_mem_test_pkg.sv
// Shared encodings and constants for the on-chip RAM test master.
package my_nios1_mem_test_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StRead,
      StDrain,
      StDone
   } state_e;

   localparam logic [31:0] LfsrPoly = 32'h8020_0003;
   localparam logic [31:0] Mode0Xor = 32'hA5A5_0000;

endpackage

// File: rtl/my_nios1_mem_test_pattern.sv
// Test-pattern generator: address-derived word (mode 0) or Galois LFSR word (mode 1).
module my_nios1_mem_test_pattern
   import my_nios1_mem_test_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned DATA_W    = 32,
   parameter logic [31:0] LFSR_SEED = 32'h1234_5678
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              advance,
   input  logic              mode,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] pattern
);

   logic [DATA_W-1:0] lfsr_d, lfsr_q;

   // Right-shifting Galois form: feedback taps apply when the bit shifted out is 1.
   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = DATA_W'(LFSR_SEED);
      end else if (advance) begin
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? DATA_W'(LfsrPoly) : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= DATA_W'(LFSR_SEED);
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign pattern = mode ? lfsr_q : (DATA_W'(addr) ^ DATA_W'(Mode0Xor));

endmodule

// File: rtl/my_nios1_mem_test_master.sv
// Avalon-MM RAM self-test master: write a pattern over a word range, read it back, count mismatches.
module my_nios1_mem_test_master
   import my_nios1_mem_test_pkg::*;
#(
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [31:0] LFSR_SEED    = 32'h1234_5678
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W:0]       length,
   input  logic                  mode,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [15:0]           err_count,
   output logic [ADDR_W-1:0]     first_err_addr,
   output logic [ADDR_W-1:0]     avm_address,
   output logic                  avm_read,
   output logic                  avm_write,
   output logic [DATA_W/8-1:0]   avm_byteenable,
   output logic [DATA_W-1:0]     avm_writedata,
   input  logic [DATA_W-1:0]     avm_readdata,
   input  logic                  avm_waitrequest
);

   state_e                  state_d, state_q;
   logic [ADDR_W-1:0]       base_d, base_q;
   logic [ADDR_W:0]         len_d, len_q;
   logic                    mode_d, mode_q;
   logic [ADDR_W:0]         idx_d, idx_q;
   logic [ADDR_W:0]         chk_idx_d, chk_idx_q;
   logic [READ_LATENCY-1:0] rd_vld_d, rd_vld_q;
   logic [15:0]             err_d, err_q;
   logic [ADDR_W-1:0]       first_d, first_q;
   logic                    pass_d, pass_q;

   logic                    active, acc, rd_acc, rd_ret, last;
   logic                    iss_load, iss_advance;
   logic [ADDR_W-1:0]       iss_addr, chk_addr;
   logic [DATA_W-1:0]       iss_pat, chk_pat;

   assign avm_write = (state_q == StWrite);
   assign avm_read  = (state_q == StRead);
   assign active    = avm_write | avm_read;
   assign acc       = active & ~avm_waitrequest;
   assign rd_acc    = avm_read & ~avm_waitrequest;
   assign rd_ret    = rd_vld_q[READ_LATENCY-1];
   assign last      = ((idx_q + (ADDR_W+1)'(1)) == len_q);
   assign iss_addr  = base_q + idx_q[ADDR_W-1:0];
   assign chk_addr  = base_q + chk_idx_q[ADDR_W-1:0];

   // Issue side is reseeded at the write->read turnaround so reads expect the same sequence.
   my_nios1_mem_test_pattern #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .LFSR_SEED (LFSR_SEED)
   ) u_iss_pat (
      .clk     (clk),
      .reset   (reset),
      .load    (iss_load),
      .advance (iss_advance),
      .mode    (mode_q),
      .addr    (iss_addr),
      .pattern (iss_pat)
   );

   my_nios1_mem_test_pattern #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .LFSR_SEED (LFSR_SEED)
   ) u_chk_pat (
      .clk     (clk),
      .reset   (reset),
      .load    (state_q == StIdle && start),
      .advance (rd_ret),
      .mode    (mode_q),
      .addr    (chk_addr),
      .pattern (chk_pat)
   );

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      len_d     = len_q;
      mode_d    = mode_q;
      idx_d     = idx_q;
      chk_idx_d = chk_idx_q;
      err_d     = err_q;
      first_d   = first_q;
      pass_d    = pass_q;
      iss_load  = 1'b0;

      rd_vld_d[0] = rd_acc;
      for (int i = 1; i < READ_LATENCY; i++) begin
         rd_vld_d[i] = rd_vld_q[i-1];
      end

      if (rd_ret) begin
         chk_idx_d = chk_idx_q + (ADDR_W+1)'(1);
         if (avm_readdata != chk_pat) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0) first_d = chk_addr;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               base_d    = base_addr;
               len_d     = length;
               mode_d    = mode;
               idx_d     = '0;
               chk_idx_d = '0;
               err_d     = '0;
               first_d   = '0;
               iss_load  = 1'b1;
               if (length == '0) begin
                  pass_d  = 1'b1;
                  state_d = StDone;
               end else begin
                  state_d = StWrite;
               end
            end
         end
         StWrite: begin
            if (acc) begin
               idx_d = idx_q + (ADDR_W+1)'(1);
               if (last) begin
                  idx_d    = '0;
                  iss_load = 1'b1;
                  state_d  = StRead;
               end
            end
         end
         StRead: begin
            if (acc) begin
               idx_d = idx_q + (ADDR_W+1)'(1);
               if (last) state_d = StDrain;
            end
         end
         StDrain: begin
            // Returns already folded into err_q once the valid pipe is empty.
            if (rd_vld_q == '0) begin
               pass_d  = (err_q == 16'd0);
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      iss_advance = acc & ~iss_load;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         base_q    <= '0;
         len_q     <= '0;
         mode_q    <= 1'b0;
         idx_q     <= '0;
         chk_idx_q <= '0;
         rd_vld_q  <= '0;
         err_q     <= '0;
         first_q   <= '0;
         pass_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         len_q     <= len_d;
         mode_q    <= mode_d;
         idx_q     <= idx_d;
         chk_idx_q <= chk_idx_d;
         rd_vld_q  <= rd_vld_d;
         err_q     <= err_d;
         first_q   <= first_d;
         pass_q    <= pass_d;
      end
   end

   assign busy           = (state_q != StIdle);
   assign done           = (state_q == StDone);
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_err_addr = first_q;
   assign avm_address    = active ? iss_addr : '0;
   assign avm_writedata  = avm_write ? iss_pat : '0;
   assign avm_byteenable = active ? '1 : '0;

endmodule

// File: tb/tb_my_nios1_mem_test_master.sv
// Self-checking bench: behavioural RAM slave plus a reference model of pattern, address and error rules.
module tb_my_nios1_mem_test_master;

   localparam logic [31:0] Seed = 32'h1234_5678;
   localparam logic [31:0] Poly = 32'h8020_0003;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  base_addr = '0;
   logic [10:0] length = '0;
   logic        mode = 1'b0;
   logic        busy, done, pass;
   logic [15:0] err_count;
   logic [9:0]  first_err_addr, avm_address;
   logic        avm_read, avm_write;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata = '0;
   logic        avm_waitrequest = 1'b0;

   my_nios1_mem_test_master dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .base_addr       (base_addr),
      .length          (length),
      .mode            (mode),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .err_count       (err_count),
      .first_err_addr  (first_err_addr),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_write       (avm_write),
      .avm_byteenable  (avm_byteenable),
      .avm_writedata   (avm_writedata),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem     [1024];
   logic [31:0] corrupt [1024];
   bit          rand_wait = 1'b0;

   logic [9:0]  wq_a[$];
   logic [31:0] wq_d[$];
   int          wq_t[$];
   logic [9:0]  rq_a[$];
   int          rq_t[$];

   int          cyc_q = 0;
   int          done_cnt = 0;
   int          overlap = 0;
   int          stall_viol = 0;
   int          be_viol = 0;
   bit          stall_prev = 1'b0;
   logic [9:0]  s_addr;
   logic [31:0] s_data;
   logic        s_wr, s_rd;

   // RAM slave with 1-cycle read latency, optional random stalls and per-word read corruption.
   always @(posedge clk) begin
      cyc_q <= cyc_q + 1;
      avm_waitrequest <= rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      if (done) done_cnt <= done_cnt + 1;
      if (reset) begin
         stall_prev <= 1'b0;
      end else begin
         if (avm_write && avm_read) overlap <= overlap + 1;
         if ((avm_write || avm_read) && avm_byteenable != 4'hF) be_viol <= be_viol + 1;
         if (avm_write && !avm_waitrequest) begin
            mem[avm_address] <= avm_writedata;
            wq_a.push_back(avm_address);
            wq_d.push_back(avm_writedata);
            wq_t.push_back(cyc_q);
         end
         if (avm_read && !avm_waitrequest) begin
            avm_readdata <= mem[avm_address] ^ corrupt[avm_address];
            rq_a.push_back(avm_address);
            rq_t.push_back(cyc_q);
         end else begin
            avm_readdata <= $urandom;
         end
         if (stall_prev && (avm_address != s_addr || avm_writedata != s_data ||
                            avm_write != s_wr || avm_read != s_rd))
            stall_viol <= stall_viol + 1;
         stall_prev <= (avm_write || avm_read) && avm_waitrequest;
         s_addr <= avm_address;
         s_data <= avm_writedata;
         s_wr   <= avm_write;
         s_rd   <= avm_read;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   // Word i of a test: LFSR stepped i times from the seed, or the address XOR A5A5_0000.
   function automatic logic [31:0] exp_word(input logic m, input logic [9:0] a, input int i);
      logic [31:0] s;
      s = Seed;
      for (int k = 0; k < i; k++) s = (s >> 1) ^ (s[0] ? Poly : 32'h0);
      return m ? s : ({22'h0, a} ^ 32'hA5A5_0000);
   endfunction

   task automatic run_test(input logic [9:0] b, input int len, input logic m, input bit w);
      int          w0, r0, d0, ov0, sv0, bv0, cyc, exp_err, bad_w, bad_r, max_wt, min_rt;
      logic [9:0]  exp_first, a;
      bit          seen;
      w0 = wq_a.size(); r0 = rq_a.size(); d0 = done_cnt;
      ov0 = overlap; sv0 = stall_viol; bv0 = be_viol;
      exp_err = 0; exp_first = '0;
      for (int i = 0; i < len; i++) begin
         a = b + 10'(i);
         if (corrupt[a] != 32'h0) begin
            if (exp_err == 0) exp_first = a;
            exp_err++;
         end
      end
      rand_wait = w;
      base_addr = b; length = 11'(len); mode = m; start = 1'b1;
      tick();
      start = 1'b0; base_addr = 10'($urandom); length = 11'($urandom); mode = 1'($urandom);
      cyc = 0; seen = 1'b0;
      while (cyc < 10 * len + 20 && !seen) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (cyc == 2 && busy) start = 1'b1;  // must be ignored mid-test
            tick();
            start = 1'b0;
            cyc++;
         end
      end
      rand_wait = 1'b0;
      check("done_seen", 32'(seen), 32'd1);
      check("pass", 32'(pass), 32'(exp_err == 0));
      check("err_count", 32'(err_count), 32'(exp_err));
      check("first_err_addr", 32'(first_err_addr), 32'(exp_first));
      check("writes_accepted", 32'(wq_a.size() - w0), 32'(len));
      check("reads_accepted", 32'(rq_a.size() - r0), 32'(len));
      bad_w = 0; bad_r = 0; max_wt = -1; min_rt = 32'h7fff_ffff;
      for (int i = 0; i < len && w0 + i < wq_a.size(); i++) begin
         a = b + 10'(i);
         if (wq_a[w0+i] !== a || wq_d[w0+i] !== exp_word(m, a, i)) bad_w++;
         if (wq_t[w0+i] > max_wt) max_wt = wq_t[w0+i];
      end
      for (int i = 0; i < len && r0 + i < rq_a.size(); i++) begin
         if (rq_a[r0+i] !== b + 10'(i)) bad_r++;
         if (rq_t[r0+i] < min_rt) min_rt = rq_t[r0+i];
      end
      check("write_sequence_bad", 32'(bad_w), 32'd0);
      check("read_sequence_bad", 32'(bad_r), 32'd0);
      check("reads_after_writes", 32'(max_wt < min_rt), 32'd1);
      check("rd_wr_overlap", 32'(overlap - ov0), 32'd0);
      check("byteenable_bad", 32'(be_viol - bv0), 32'd0);
      if (w) check("stall_hold_bad", 32'(stall_viol - sv0), 32'd0);
      if (len == 0) check("len0_latency", 32'(cyc <= 2), 32'd1);
      else if (!w) check("latency_bound", 32'(cyc <= 2 * len + 5), 32'd1);
      tick();
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
      check("done_count", 32'(done_cnt - d0), 32'd1);
   endtask

   initial begin
      int         cyc, d0, len, ca;
      logic [9:0] b;
      logic       m;
      for (int i = 0; i < 1024; i++) begin
         corrupt[i] = '0;
         mem[i] = '0;
      end

      reset = 1'b1;
      tick(); tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd1);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_first_err", 32'(first_err_addr), 32'd0);
      check("rst_avm_ctrl", {avm_read, avm_write, avm_byteenable}, 32'd0);
      check("rst_avm_addr", 32'(avm_address), 32'd0);
      check("rst_avm_wdata", avm_writedata, 32'd0);
      reset = 1'b0;
      tick();

      // Ideal RAM, address pattern.
      run_test(10'h000, 16, 1'b0, 1'b0);
      check("word5_data", wq_d[wq_d.size() - 16 + 5], 32'hA5A5_0005);

      // Wrap past the top of the address space, LFSR pattern.
      run_test(10'h3FC, 8, 1'b1, 1'b0);
      check("wrap_addr4", 32'(wq_a[wq_a.size() - 8 + 4]), 32'h000);
      check("wrap_rd_addr3", 32'(rq_a[rq_a.size() - 8 + 3]), 32'h3FF);

      // Bit-0 corruption at words 3 and 7.
      corrupt[3] = 32'h1; corrupt[7] = 32'h1;
      run_test(10'h000, 10, 1'b0, 1'b0);
      corrupt[3] = '0; corrupt[7] = '0;

      // Zero-length test.
      run_test(10'h123, 0, 1'b0, 1'b0);

      // Randomized runs, odd ones with 50% waitrequest, some with a corrupted word.
      for (int t = 0; t < 6; t++) begin
         b = 10'($urandom);
         len = $urandom_range(1, 40);
         m = 1'($urandom);
         ca = -1;
         if (t == 2 || t == 5) begin
            ca = int'(b + 10'($urandom_range(0, len - 1)));
            corrupt[ca] = 32'h1 << $urandom_range(0, 31);
         end
         run_test(b, len, m, t[0]);
         if (ca >= 0) corrupt[ca] = '0;
      end

      // Reset in the middle of the read phase.
      base_addr = 10'h040; length = 11'd20; mode = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (!avm_read && cyc < 200) begin
         tick();
         cyc++;
      end
      check("reached_read", 32'(avm_read), 32'd1);
      tick(); tick();
      d0 = done_cnt;
      reset = 1'b1;
      tick();
      check("midrst_avm_ctrl", {avm_read, avm_write, avm_byteenable}, 32'd0);
      check("midrst_avm_addr", 32'(avm_address), 32'd0);
      check("midrst_avm_wdata", avm_writedata, 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      reset = 1'b0;
      repeat (5) tick();
      check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
      run_test(10'h040, 20, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
